// File: rtl/wb_master_bridge.sv
// Single-request valid/ready to Wishbone classic master bridge.
// Handles interconnect grant, retry with one-cycle backoff, timeout, and a one-cycle response pulse.
module wb_master_bridge #(
    parameter int TAGSIZE   = 2,
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [31:0]        req_adr_i,
    input  logic [31:0]        req_dat_i,
    input  logic [3:0]         req_sel_i,
    input  logic [TAGSIZE-1:0] req_tgc_i,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_dat_o,
    output logic [TAGSIZE-1:0] rsp_tgd_o,
    output logic               rsp_err_o,
    output logic               rsp_timeout_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic               wb_lock_o,
    output logic [31:0]        wb_adr_o,
    output logic [31:0]        wb_dat_o,
    output logic [3:0]         wb_sel_o,
    output logic [TAGSIZE-1:0] wb_tga_o,
    output logic [TAGSIZE-1:0] wb_tgd_o,
    output logic [TAGSIZE-1:0] wb_tgc_o,
    input  logic [31:0]        wb_dat_i,
    input  logic [TAGSIZE-1:0] wb_tgd_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i,
    input  logic               wb_gnt_i
);

    localparam int              RW            = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0]   RETRY_LIMIT   = RW'(MAX_RETRY);
    localparam logic [15:0]     TIMEOUT_LIMIT = 16'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [RW-1:0]       r_rty_cnt;
    logic [15:0]         r_to_cnt;
    logic                r_we;
    logic [31:0]         r_adr;
    logic [31:0]         r_dat;
    logic [3:0]          r_sel;
    logic [TAGSIZE-1:0]  r_tgc;
    logic [31:0]         r_rsp_dat;
    logic [TAGSIZE-1:0]  r_rsp_tgd;
    logic                r_rsp_err;
    logic                r_rsp_to;

    logic                w_accept;
    logic                w_granted;
    logic                w_rty_done;
    logic [15:0]         w_to_inc;
    logic                w_to_hit;

    // Broadcast responses only belong to us while we hold the grant in BUS.
    assign w_accept   = req_valid_i & req_ready_o;
    assign w_granted  = (r_state == S_BUS) & wb_gnt_i;
    assign w_rty_done = (r_rty_cnt == RETRY_LIMIT);
    assign w_to_inc   = (r_to_cnt == 16'hFFFF) ? r_to_cnt : r_to_cnt + 16'd1;
    assign w_to_hit   = (TIMEOUT_LIMIT != 16'd0) && (w_to_inc == TIMEOUT_LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_next = S_BUS;
            S_BUS: begin
                if (w_granted) begin
                    if (wb_ack_i || wb_err_i) w_next = S_RESP;
                    else if (wb_rty_i)        w_next = w_rty_done ? S_RESP : S_BACKOFF;
                    else if (w_to_hit)        w_next = S_RESP;
                end
            end
            S_BACKOFF: w_next = S_BUS;
            S_RESP:    w_next = w_accept ? S_BUS : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (r_state)
            S_IDLE:  req_ready_o = !rst_i;
            S_BUS: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
            end
            S_RESP: begin
                req_ready_o = !rst_i;
                rsp_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rty_cnt <= '0;
            r_to_cnt  <= '0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_tgc     <= '0;
            r_rsp_dat <= '0;
            r_rsp_tgd <= '0;
            r_rsp_err <= 1'b0;
            r_rsp_to  <= 1'b0;
        end else begin
            // Response fields are valid only for the single RESP cycle.
            r_rsp_dat <= '0;
            r_rsp_tgd <= '0;
            r_rsp_err <= 1'b0;
            r_rsp_to  <= 1'b0;

            if (w_accept) begin
                r_we      <= req_we_i;
                r_adr     <= req_adr_i;
                r_dat     <= req_dat_i;
                r_sel     <= req_sel_i;
                r_tgc     <= req_tgc_i;
                r_rty_cnt <= '0;
                r_to_cnt  <= '0;
            end

            if (r_state == S_BACKOFF) r_to_cnt <= '0;

            if (w_granted) begin
                if (wb_ack_i) begin
                    r_rsp_dat <= r_we ? 32'd0 : wb_dat_i;
                    r_rsp_tgd <= r_we ? '0 : wb_tgd_i;
                end else if (wb_err_i) begin
                    r_rsp_err <= 1'b1;
                end else if (wb_rty_i) begin
                    if (w_rty_done) r_rsp_err <= 1'b1;
                    else            r_rty_cnt <= r_rty_cnt + RW'(1);
                end else begin
                    r_to_cnt <= w_to_inc;
                    if (w_to_hit) begin
                        r_rsp_err <= 1'b1;
                        r_rsp_to  <= 1'b1;
                    end
                end
            end
        end
    end

    assign wb_lock_o     = wb_cyc_o;
    assign wb_we_o       = r_we;
    assign wb_adr_o      = r_adr;
    assign wb_dat_o      = r_dat;
    assign wb_sel_o      = r_sel;
    assign wb_tgc_o      = r_tgc;
    assign wb_tga_o      = '0;
    assign wb_tgd_o      = '0;
    assign rsp_dat_o     = r_rsp_dat;
    assign rsp_tgd_o     = r_rsp_tgd;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_to;

endmodule
